// File: rtl/game_pkg.sv
// Shared game types: the top-level FSM state encoding and sprite placement constants.
package game_pkg;

  typedef enum logic [2:0] {
    StMenu  = 3'd0,
    StPlay  = 3'd1,
    StPause = 3'd2,
    StClear = 3'd3,
    StWin   = 3'd4,
    StLose  = 3'd5
  } state_t;

  // Sprites start this many px in from the bottom (player) / top (enemy) edge.
  localparam int unsigned SpriteMargin = 32;

  function automatic int unsigned start_x(input int unsigned field_w);
    return field_w / 2;
  endfunction

endpackage

// File: rtl/game_axis_mover.sv
// One sprite axis: signed step, clamp to 0..LIMIT, and a bounce flag when the clamp engaged.
module game_axis_mover #(
  parameter int unsigned POS_W = 10,
  parameter int unsigned LIMIT = 639
) (
  input  logic        [POS_W-1:0] pos,
  input  logic signed [POS_W+1:0] step,
  output logic        [POS_W-1:0] next_pos,
  output logic                    bounce
);

  localparam logic signed [POS_W+1:0] Lim = (POS_W+2)'(LIMIT);

  logic signed [POS_W+1:0] sum;

  always_comb begin
    sum      = $signed({2'b00, pos}) + step;
    next_pos = sum[POS_W-1:0];
    bounce   = 1'b0;
    if (sum < 0) begin
      next_pos = '0;
      bounce   = 1'b1;
    end else if (sum > Lim) begin
      next_pos = Lim[POS_W-1:0];
      bounce   = 1'b1;
    end
  end

endmodule

// File: rtl/game_core.sv
// Registered game state: FSM, level, HP counters and sprite positions, advanced per frame_tick.
// Optional invulnerability frames after a player hit are built when GAME_IFRAME_EN is defined.
module game_core
  import game_pkg::*;
#(
  parameter int unsigned NUM_LEVELS      = 3,
  parameter int unsigned LVL_W           = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1,
  parameter int unsigned POS_W           = 10,
  parameter int unsigned FIELD_W         = 640,
  parameter int unsigned FIELD_H         = 480,
  parameter int unsigned HP_W            = 8,
  parameter int unsigned PLAYER_HP_INIT  = 5,
  parameter int unsigned ENEMY_HP_BASE   = 10,
  parameter int unsigned ENEMY_HP_STEP   = 5,
  parameter int unsigned PLAYER_STEP     = 4,
  parameter int unsigned ENEMY_STEP_BASE = 2,
  parameter int unsigned IFRAME_TICKS    = 30
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_tick,
  input  logic             enter,
  input  logic             pause,
  input  logic             up,
  input  logic             down,
  input  logic             left,
  input  logic             right,
  input  logic             player_hit,
  input  logic             enemy_hit,
  output state_t           state,
  output logic [LVL_W-1:0] level,
  output logic [HP_W-1:0]  player_hp,
  output logic [HP_W-1:0]  enemy_hp,
  output logic [POS_W-1:0] player_x,
  output logic [POS_W-1:0] player_y,
  output logic [POS_W-1:0] enemy_x,
  output logic [POS_W-1:0] enemy_y,
  output logic             player_invuln
);

  localparam logic [POS_W-1:0]        PlayerX0  = POS_W'(start_x(FIELD_W));
  localparam logic [POS_W-1:0]        PlayerY0  = POS_W'(FIELD_H - SpriteMargin);
  localparam logic [POS_W-1:0]        EnemyY0   = POS_W'(SpriteMargin);
  localparam logic [HP_W-1:0]         PlayerHp0 = HP_W'(PLAYER_HP_INIT);
  localparam logic [HP_W-1:0]         EnemyHp0  = HP_W'(ENEMY_HP_BASE);
  localparam logic [LVL_W-1:0]        LastLevel = LVL_W'(NUM_LEVELS - 1);
  localparam logic signed [POS_W+1:0] PStep     = (POS_W+2)'(PLAYER_STEP);

  state_t             state_q, state_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [HP_W-1:0]    player_hp_q, player_hp_d, enemy_hp_q, enemy_hp_d;
  logic [POS_W-1:0]   player_x_q, player_x_d, player_y_q, player_y_d, enemy_x_q, enemy_x_d;
  logic               enemy_dir_q, enemy_dir_d;  // 1 = moving +x
  logic               enter_prev_q, pause_prev_q;
  logic               enter_rise, pause_rise, hit_p, reload_pos;

  logic signed [POS_W+1:0] px_step, py_step, ex_step, es_mag;
  logic [POS_W-1:0]        px_next, py_next, ex_next;
  logic                    ex_bounce, unused_px_bounce, unused_py_bounce;

`ifdef GAME_IFRAME_EN
  localparam int unsigned IfrW = $clog2(IFRAME_TICKS + 1);
  logic [IfrW-1:0] iframe_q, iframe_d;
  assign player_invuln = (iframe_q != '0);
`else
  localparam int unsigned unused_iframe_ticks = IFRAME_TICKS;
  assign player_invuln = 1'b0;
`endif

  always_comb begin
    px_step = '0;
    py_step = '0;
    if (right && !left) px_step = PStep;
    else if (left && !right) px_step = -PStep;
    if (down && !up) py_step = PStep;
    else if (up && !down) py_step = -PStep;
    es_mag  = (POS_W+2)'(ENEMY_STEP_BASE) + (POS_W+2)'(level_q);
    ex_step = enemy_dir_q ? es_mag : -es_mag;
  end

  game_axis_mover #(.POS_W(POS_W), .LIMIT(FIELD_W - 1)) u_player_x (
    .pos(player_x_q), .step(px_step), .next_pos(px_next), .bounce(unused_px_bounce)
  );
  game_axis_mover #(.POS_W(POS_W), .LIMIT(FIELD_H - 1)) u_player_y (
    .pos(player_y_q), .step(py_step), .next_pos(py_next), .bounce(unused_py_bounce)
  );
  game_axis_mover #(.POS_W(POS_W), .LIMIT(FIELD_W - 1)) u_enemy_x (
    .pos(enemy_x_q), .step(ex_step), .next_pos(ex_next), .bounce(ex_bounce)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    player_hp_d = player_hp_q;
    enemy_hp_d  = enemy_hp_q;
    player_x_d  = player_x_q;
    player_y_d  = player_y_q;
    enemy_x_d   = enemy_x_q;
    enemy_dir_d = enemy_dir_q;
`ifdef GAME_IFRAME_EN
    iframe_d    = iframe_q;
`endif
    reload_pos  = 1'b0;
    hit_p       = player_hit;
    enter_rise  = enter & ~enter_prev_q;
    pause_rise  = pause & ~pause_prev_q;

    unique case (state_q)
      StMenu: if (enter_rise) begin
        state_d     = StPlay;
        level_d     = '0;
        player_hp_d = PlayerHp0;
        enemy_hp_d  = EnemyHp0;
        reload_pos  = 1'b1;
      end
      StPlay: begin
        if (frame_tick) begin
          player_x_d = px_next;
          player_y_d = py_next;
          enemy_x_d  = ex_next;
          if (ex_bounce) enemy_dir_d = ~enemy_dir_q;
`ifdef GAME_IFRAME_EN
          if (iframe_q != '0) begin
            iframe_d = iframe_q - 1'b1;
            hit_p    = 1'b0;
          end else if (player_hit) begin
            iframe_d = IfrW'(IFRAME_TICKS);
          end
`endif
          if (hit_p && player_hp_q != '0) player_hp_d = player_hp_q - 1'b1;
          if (enemy_hit && enemy_hp_q != '0) enemy_hp_d = enemy_hp_q - 1'b1;
          // End-of-round outcomes take priority over a simultaneous pause press.
          if (player_hp_d == '0) state_d = StLose;
          else if (enemy_hp_d == '0) state_d = (level_q == LastLevel) ? StWin : StClear;
          else if (pause_rise) state_d = StPause;
        end else if (pause_rise) begin
          state_d = StPause;
        end
      end
      StPause: if (pause_rise) state_d = StPlay;
      StClear: if (enter_rise) begin
        state_d    = StPlay;
        level_d    = level_q + 1'b1;
        enemy_hp_d = HP_W'(ENEMY_HP_BASE + ENEMY_HP_STEP * (int'(level_q) + 1));
        reload_pos = 1'b1;
      end
      StWin, StLose: if (enter_rise) begin
        state_d = StMenu;
`ifdef GAME_IFRAME_EN
        iframe_d = '0;
`endif
      end
      default: state_d = StMenu;
    endcase

    if (reload_pos) begin
      player_x_d  = PlayerX0;
      player_y_d  = PlayerY0;
      enemy_x_d   = PlayerX0;
      enemy_dir_d = 1'b1;
`ifdef GAME_IFRAME_EN
      iframe_d    = '0;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StMenu;
      level_q      <= '0;
      player_hp_q  <= PlayerHp0;
      enemy_hp_q   <= EnemyHp0;
      player_x_q   <= PlayerX0;
      player_y_q   <= PlayerY0;
      enemy_x_q    <= PlayerX0;
      enemy_dir_q  <= 1'b1;
      enter_prev_q <= 1'b1;
      pause_prev_q <= 1'b1;
`ifdef GAME_IFRAME_EN
      iframe_q     <= '0;
`endif
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      player_hp_q  <= player_hp_d;
      enemy_hp_q   <= enemy_hp_d;
      player_x_q   <= player_x_d;
      player_y_q   <= player_y_d;
      enemy_x_q    <= enemy_x_d;
      enemy_dir_q  <= enemy_dir_d;
      enter_prev_q <= enter;
      pause_prev_q <= pause;
`ifdef GAME_IFRAME_EN
      iframe_q     <= iframe_d;
`endif
    end
  end

  assign state     = state_q;
  assign level     = level_q;
  assign player_hp = player_hp_q;
  assign enemy_hp  = enemy_hp_q;
  assign player_x  = player_x_q;
  assign player_y  = player_y_q;
  assign enemy_x   = enemy_x_q;
  assign enemy_y   = EnemyY0;

endmodule

// File: tb/tb_game_core.sv
// Scoreboard bench for game_core: a driver feeds directed and random cycles into an integer-level
// game model and queues the expected outputs; a monitor compares them after each clock edge.
`timescale 1ns/1ps
module tb_game_core;
  import game_pkg::*;

  localparam int FW = 640, FH = 480, NL = 3, PHP0 = 5, EHP0 = 10, EHPS = 5;
  localparam int PSTEP = 4, ESTEP0 = 2, IFR = 30;

  logic clk = 1'b0;
  logic rst, frame_tick, enter, pause, up, down, left, right, player_hit, enemy_hit;
  state_t     state;
  logic [1:0] level;
  logic [7:0] player_hp, enemy_hp;
  logic [9:0] player_x, player_y, enemy_x, enemy_y;
  logic       player_invuln;

  game_core dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .enter(enter), .pause(pause),
    .up(up), .down(down), .left(left), .right(right),
    .player_hit(player_hit), .enemy_hit(enemy_hit),
    .state(state), .level(level), .player_hp(player_hp), .enemy_hp(enemy_hp),
    .player_x(player_x), .player_y(player_y), .enemy_x(enemy_x), .enemy_y(enemy_y),
    .player_invuln(player_invuln)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic rst, tick, enter, pause, up, down, left, right, ph, eh;
  } stim_t;

  typedef struct packed {
    logic [2:0] st;
    logic [1:0] lvl;
    logic [7:0] php, ehp;
    logic [9:0] px, py, ex, ey;
    logic       inv;
  } snap_t;

  snap_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;

  // Game model in plain integers
  state_t m_st;
  int     m_lvl, m_php, m_ehp, m_px, m_py, m_ex, m_dir, m_ifr;
  bit     m_eprev, m_pprev;

  function automatic int clamp(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  task automatic load_positions();
    m_px = FW / 2; m_py = FH - 32; m_ex = FW / 2; m_dir = 1; m_ifr = 0;
  endtask

  task automatic model_step(input stim_t s);
    bit er, pr, ph;
    int nx;
    if (s.rst) begin
      m_st = StMenu; m_lvl = 0; m_php = PHP0; m_ehp = EHP0;
      load_positions();
      m_eprev = 1'b1; m_pprev = 1'b1;
      return;
    end
    er = s.enter && !m_eprev;
    pr = s.pause && !m_pprev;
    m_eprev = s.enter;
    m_pprev = s.pause;
    case (m_st)
      StMenu: if (er) begin
        m_st = StPlay; m_lvl = 0; m_php = PHP0; m_ehp = EHP0; load_positions();
      end
      StPlay: begin
        if (s.tick) begin
          m_px = clamp(m_px + PSTEP * (int'(s.right) - int'(s.left)), FW - 1);
          m_py = clamp(m_py + PSTEP * (int'(s.down) - int'(s.up)), FH - 1);
          nx = m_ex + m_dir * (ESTEP0 + m_lvl);
          if (nx < 0 || nx > FW - 1) m_dir = -m_dir;
          m_ex = clamp(nx, FW - 1);
          ph = s.ph;
`ifdef GAME_IFRAME_EN
          if (m_ifr > 0) begin m_ifr--; ph = 1'b0; end
          else if (ph) m_ifr = IFR;
`endif
          if (ph && m_php > 0) m_php--;
          if (s.eh && m_ehp > 0) m_ehp--;
          if (m_php == 0) m_st = StLose;
          else if (m_ehp == 0) m_st = (m_lvl == NL - 1) ? StWin : StClear;
          else if (pr) m_st = StPause;
        end else if (pr) m_st = StPause;
      end
      StPause: if (pr) m_st = StPlay;
      StClear: if (er) begin
        m_st = StPlay; m_lvl++; m_ehp = EHP0 + EHPS * m_lvl; load_positions();
      end
      default: if (er) begin m_st = StMenu; m_ifr = 0; end
    endcase
  endtask

  function automatic snap_t model_snap();
    snap_t e;
    e.st = 3'(m_st); e.lvl = 2'(m_lvl); e.php = 8'(m_php); e.ehp = 8'(m_ehp);
    e.px = 10'(m_px); e.py = 10'(m_py); e.ex = 10'(m_ex); e.ey = 10'd32;
    e.inv = (m_ifr > 0);
    return e;
  endfunction

  // Driver: apply one cycle of stimulus at the falling edge and queue the post-edge expectation.
  task automatic drive(input stim_t s);
    @(negedge clk);
    rst = s.rst; frame_tick = s.tick; enter = s.enter; pause = s.pause;
    up = s.up; down = s.down; left = s.left; right = s.right;
    player_hit = s.ph; enemy_hit = s.eh;
    model_step(s);
    exp_q.push_back(model_snap());
  endtask

  task automatic frames(input stim_t s, input int n);
    stim_t t;
    for (int i = 0; i < n; i++) begin
      t = s; t.tick = 1'b1; drive(t);
      t = s; t.tick = 1'b0; t.ph = 1'b0; t.eh = 1'b0; drive(t);
    end
  endtask

  // Monitor
  initial begin
    snap_t e, g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {3'(state), level, player_hp, enemy_hp, player_x, player_y, enemy_x, enemy_y,
             player_invuln};
        checks++;
        if (g !== e) begin
          errors++;
          $display("FAIL snapshot cyc=%0d got st=%0d lvl=%0d hp=%0d/%0d p=(%0d,%0d) e=(%0d,%0d) inv=%0b required st=%0d lvl=%0d hp=%0d/%0d p=(%0d,%0d) e=(%0d,%0d) inv=%0b",
                   cyc, g.st, g.lvl, g.php, g.ehp, g.px, g.py, g.ex, g.ey, g.inv,
                   e.st, e.lvl, e.php, e.ehp, e.px, e.py, e.ex, e.ey, e.inv);
        end
      end
    end
  end

  initial begin
    stim_t s;
    // Enter held through reset must not start the game.
    s = '0; s.rst = 1'b1; s.enter = 1'b1;
    repeat (3) drive(s);
    s.rst = 1'b0;
    repeat (3) drive(s);
    s.enter = 1'b0; drive(s);
    s.enter = 1'b1; drive(s);
    s.enter = 1'b0; drive(s);
    // Player pinned right; enemy bounces off the right wall.
    s.right = 1'b1; frames(s, 200); s.right = 1'b0;
    // Clear level 0 and advance.
    s.eh = 1'b1; frames(s, 10); s.eh = 1'b0;
    s.enter = 1'b1; drive(s); s.enter = 1'b0; drive(s);
    // Level-1 patrol with random movement, long enough to reach both walls.
    for (int i = 0; i < 450; i++) begin
      s.up = 1'($urandom_range(0, 1)); s.down = 1'($urandom_range(0, 1));
      s.left = 1'($urandom_range(0, 1)); s.right = 1'($urandom_range(0, 1));
      frames(s, 1);
    end
    // Pause: hits and ticks while paused change nothing.
    s.pause = 1'b1; drive(s); s.pause = 1'b0;
    s.ph = 1'b1; s.eh = 1'b1; frames(s, 5); s.ph = 1'b0; s.eh = 1'b0;
    s.pause = 1'b1; drive(s); s.pause = 1'b0; drive(s);
    // Drive both HPs to 1, then a double hit ends in LOSE.
    s.ph = 1'b1; frames(s, 4); s.ph = 1'b0;
    s.eh = 1'b1; frames(s, 14);
    s.ph = 1'b1; frames(s, 1); s.ph = 1'b0; s.eh = 1'b0;
    s.enter = 1'b1; drive(s); s.enter = 1'b0; drive(s);
    // Random play, including pause/tick coincidences and occasional reset.
    s = '0;
    for (int i = 0; i < 6000; i++) begin
      s.rst  = ($urandom_range(0, 999) == 0);
      s.tick = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 9) == 0) s.enter = ~s.enter;
      if ($urandom_range(0, 29) == 0) s.pause = ~s.pause;
      if ($urandom_range(0, 7) == 0) begin
        s.up = 1'($urandom_range(0, 1)); s.down = 1'($urandom_range(0, 1));
        s.left = 1'($urandom_range(0, 1)); s.right = 1'($urandom_range(0, 1));
      end
      s.ph = ($urandom_range(0, 99) < 3);
      s.eh = ($urandom_range(0, 99) < 30);
      drive(s);
    end
    s = '0; drive(s); drive(s);
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
